// File: rtl/elbeth_branch_ctrl_pkg.sv
// Shared definitions for the elbeth control-transfer resolver: branch-unit op codes
// and the resolver FSM state encoding.
package elbeth_branch_ctrl_pkg;

  localparam logic [2:0] OP_JAL  = 3'd0;
  localparam logic [2:0] OP_JALR = 3'd1;
  localparam logic [2:0] OP_BEQ  = 3'd2;
  localparam logic [2:0] OP_BNE  = 3'd3;
  localparam logic [2:0] OP_BLT  = 3'd4;
  localparam logic [2:0] OP_BGE  = 3'd5;
  localparam logic [2:0] OP_BLTU = 3'd6;
  localparam logic [2:0] OP_BGEU = 3'd7;

  typedef enum logic [1:0] {
    BRC_IDLE  = 2'd0,
    BRC_WAIT  = 2'd1,
    BRC_REDIR = 2'd2
  } brc_state_e;

endpackage

// File: rtl/elbeth_branch_ctrl_unit.sv
// elbeth_branch_unit: combinational condition evaluation and raw target computation
// for JAL/JALR/Bxx. JALR bit-0 clearing is left to the caller.
module elbeth_branch_unit
  import elbeth_branch_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] offset,
  input  logic [XLEN-1:0] data_rs1,
  input  logic [XLEN-1:0] data_rs2,
  output logic            taken,
  output logic [XLEN-1:0] pc_branch
);

  always_comb begin
    taken     = 1'b0;
    pc_branch = pc + offset;
    case (op)
      OP_JAL:  taken = 1'b1;
      OP_JALR: begin
        taken     = 1'b1;
        pc_branch = data_rs1 + offset;
      end
      OP_BEQ:  taken = (data_rs1 == data_rs2);
      OP_BNE:  taken = (data_rs1 != data_rs2);
      OP_BLT:  taken = ($signed(data_rs1) <  $signed(data_rs2));
      OP_BGE:  taken = ($signed(data_rs1) >= $signed(data_rs2));
      OP_BLTU: taken = (data_rs1 <  data_rs2);
      OP_BGEU: taken = (data_rs1 >= data_rs2);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/elbeth_branch_ctrl.sv
// Control-transfer resolver in ID: waits out operand hazards, resolves through the
// branch unit, and issues a registered IF redirect or a misaligned-target exception.
module elbeth_branch_ctrl
  import elbeth_branch_ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic             id_is_ctrl,
  input  logic [2:0]       id_op,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_offset,
  input  logic [XLEN-1:0]  id_data_rs1,
  input  logic [XLEN-1:0]  id_data_rs2,
  input  logic             id_opnd_hazard,
  input  logic             ex_flush,
  input  logic             redirect_ready,
  output logic             id_stall,
  output logic             id_kill,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             exc_misaligned,
  output logic [XLEN-1:0]  exc_pc,
  output logic [XLEN-1:0]  exc_tval,
  output logic [CNT_W-1:0] cnt_resolved,
  output logic [CNT_W-1:0] cnt_taken,
  output logic [1:0]       dbg_state
);

  // Redirect handshake: redirect_valid rises the cycle after a taken resolve and,
  // together with redirect_pc, holds stable until a cycle where redirect_ready is
  // also high; that cycle is the transfer, and valid drops on the next edge.

  brc_state_e      state;
  logic            bu_taken;
  logic [XLEN-1:0] bu_pc_branch;
  logic [XLEN-1:0] target;
  logic            req;
  logic            can_resolve;
  logic            resolve;
  logic            misaligned;

  elbeth_branch_unit #(.XLEN(XLEN)) u_branch_unit (
    .op        (id_op),
    .pc        (id_pc),
    .offset    (id_offset),
    .data_rs1  (id_data_rs1),
    .data_rs2  (id_data_rs2),
    .taken     (bu_taken),
    .pc_branch (bu_pc_branch)
  );

  assign req         = id_valid & id_is_ctrl & ~ex_flush;
  assign can_resolve = (state == BRC_IDLE) | (state == BRC_WAIT);
  assign resolve     = req & ~id_opnd_hazard & can_resolve;
  assign id_stall    = req & id_opnd_hazard & can_resolve;
  assign target      = (id_op == OP_JALR) ? {bu_pc_branch[XLEN-1:1], 1'b0} : bu_pc_branch;
  assign misaligned  = (target[1:0] != 2'b00);
  assign dbg_state   = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= BRC_IDLE;
      id_kill        <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      exc_misaligned <= 1'b0;
      exc_pc         <= '0;
      exc_tval       <= '0;
      cnt_resolved   <= '0;
      cnt_taken      <= '0;
    end else begin
      exc_misaligned <= 1'b0;
      if (ex_flush) begin
        state          <= BRC_IDLE;
        redirect_valid <= 1'b0;
        id_kill        <= 1'b0;
      end else begin
        case (state)
          BRC_IDLE, BRC_WAIT: begin
            if (resolve) begin
              cnt_resolved <= cnt_resolved + 1'b1;
              state        <= BRC_IDLE;
              if (bu_taken && misaligned) begin
                exc_misaligned <= 1'b1;
                exc_pc         <= id_pc;
                exc_tval       <= target;
              end else if (bu_taken) begin
                cnt_taken      <= cnt_taken + 1'b1;
                redirect_valid <= 1'b1;
                redirect_pc    <= target;
                id_kill        <= 1'b1;
                state          <= BRC_REDIR;
              end
            end else if (req && id_opnd_hazard) begin
              state <= BRC_WAIT;
            end else begin
              state <= BRC_IDLE;
            end
          end
          BRC_REDIR: begin
            if (redirect_ready) begin
              redirect_valid <= 1'b0;
              id_kill        <= 1'b0;
              state          <= BRC_IDLE;
            end
          end
          default: state <= BRC_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_elbeth_branch_ctrl.sv
// Directed bench for elbeth_branch_ctrl: redirects and exceptions go through a
// scoreboard queue checked by a negedge monitor; stalls/counters checked inline.
module tb_elbeth_branch_ctrl;
  import elbeth_branch_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_is_ctrl, id_opnd_hazard, ex_flush, redirect_ready;
  logic [2:0]  id_op;
  logic [31:0] id_pc, id_offset, id_data_rs1, id_data_rs2;
  logic        id_stall, id_kill, redirect_valid, exc_misaligned;
  logic [31:0] redirect_pc, exc_pc, exc_tval, cnt_resolved, cnt_taken;
  logic [1:0]  dbg_state;

  // {kind (0 redirect, 1 exception), pc, tval}
  logic [64:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_resolved = 0;
  logic [31:0] exp_taken    = 0;

  elbeth_branch_ctrl #(.XLEN(32), .CNT_W(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_valid       (id_valid),
    .id_is_ctrl     (id_is_ctrl),
    .id_op          (id_op),
    .id_pc          (id_pc),
    .id_offset      (id_offset),
    .id_data_rs1    (id_data_rs1),
    .id_data_rs2    (id_data_rs2),
    .id_opnd_hazard (id_opnd_hazard),
    .ex_flush       (ex_flush),
    .redirect_ready (redirect_ready),
    .id_stall       (id_stall),
    .id_kill        (id_kill),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .exc_misaligned (exc_misaligned),
    .exc_pc         (exc_pc),
    .exc_tval       (exc_tval),
    .cnt_resolved   (cnt_resolved),
    .cnt_taken      (cnt_taken),
    .dbg_state      (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // monitor: every handshake or exception pulse must match the head of the queue
  always @(negedge clk) begin
    logic [64:0] e;
    if (rst_n) begin
      if (redirect_valid && redirect_ready) begin
        if (exp_q.size() == 0) check("unexpected_redirect", redirect_pc, 32'hdeadbeef);
        else begin
          e = exp_q.pop_front();
          check("redirect_kind", 32'(1'b0), 32'(e[64]));
          check("redirect_pc", redirect_pc, e[63:32]);
        end
      end
      if (exc_misaligned) begin
        if (exp_q.size() == 0) check("unexpected_exc", exc_tval, 32'hdeadbeef);
        else begin
          e = exp_q.pop_front();
          check("exc_kind", 32'(1'b1), 32'(e[64]));
          check("exc_pc", exc_pc, e[63:32]);
          check("exc_tval", exc_tval, e[31:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic set_id(input logic [2:0] op, input logic [31:0] pc, input logic [31:0] off,
                        input logic [31:0] rs1, input logic [31:0] rs2, input logic haz);
    id_valid       = 1'b1;
    id_is_ctrl     = 1'b1;
    id_op          = op;
    id_pc          = pc;
    id_offset      = off;
    id_data_rs1    = rs1;
    id_data_rs2    = rs2;
    id_opnd_hazard = haz;
  endtask

  task automatic clear_id();
    id_valid       = 1'b0;
    id_is_ctrl     = 1'b0;
    id_opnd_hazard = 1'b0;
  endtask

  task automatic check_counters();
    check("cnt_resolved", cnt_resolved, exp_resolved);
    check("cnt_taken", cnt_taken, exp_taken);
  endtask

  task automatic run_xfer(input logic [2:0] op, input logic [31:0] pc, input logic [31:0] off,
                          input logic [31:0] rs1, input logic [31:0] rs2, input int haz,
                          input int rdy_dly, input logic taken, input logic [31:0] tgt);
    logic exc;
    logic redir;
    exc   = taken && (tgt[1:0] != 2'b00);
    redir = taken && !exc;
    set_id(op, pc, off, rs1, rs2, haz > 0);
    redirect_ready = (rdy_dly == 0);
    for (int i = 0; i < haz; i++) begin
      @(negedge clk);
      check("stall_hazard", 32'(id_stall), 1);
      tick();
    end
    id_opnd_hazard = 1'b0;
    if (redir) exp_q.push_back({1'b0, tgt, 32'h0});
    if (exc) exp_q.push_back({1'b1, pc, tgt});
    @(negedge clk);
    check("stall_resolve", 32'(id_stall), 0);
    tick();
    clear_id();
    exp_resolved++;
    if (redir) exp_taken++;
    if (redir) begin
      for (int i = 0; i < rdy_dly; i++) begin
        @(negedge clk);
        check("redir_hold_valid", 32'(redirect_valid), 1);
        check("redir_hold_pc", redirect_pc, tgt);
        check("redir_kill", 32'(id_kill), 1);
        tick();
      end
      redirect_ready = 1'b1;
      @(negedge clk);
      check("redir_kill_hs", 32'(id_kill), 1);
      check("redir_nostall", 32'(id_stall), 0);
      tick();
      @(negedge clk);
      check("redir_drop", 32'(redirect_valid), 0);
      check("kill_drop", 32'(id_kill), 0);
    end else begin
      @(negedge clk);
      check("no_redirect", 32'(redirect_valid), 0);
      check("exc_pulse", 32'(exc_misaligned), 32'(exc));
      tick();
      @(negedge clk);
      check("exc_one_cycle", 32'(exc_misaligned), 0);
      if (exc) check("exc_tval_hold", exc_tval, tgt);
    end
    check("state_idle", 32'(dbg_state), 32'(BRC_IDLE));
    check_counters();
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    ex_flush = 1'b0;
    redirect_ready = 1'b0;
    id_op = OP_JAL;
    id_pc = 0; id_offset = 0; id_data_rs1 = 0; id_data_rs2 = 0;
    clear_id();
    #2;
    check("rst_redirect_valid", 32'(redirect_valid), 0);
    check("rst_redirect_pc", redirect_pc, 0);
    check("rst_kill", 32'(id_kill), 0);
    check("rst_exc", 32'(exc_misaligned), 0);
    check("rst_exc_tval", exc_tval, 0);
    check("rst_state", 32'(dbg_state), 32'(BRC_IDLE));
    check_counters();
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // 1: BEQ taken, ready already high
    run_xfer(OP_BEQ, 32'h100, 32'h20, 32'd5, 32'd5, 0, 0, 1'b1, 32'h120);
    // 2: BNE not taken
    run_xfer(OP_BNE, 32'h140, 32'h20, 32'd7, 32'd7, 0, 0, 1'b0, 32'h0);
    // 3: signed vs unsigned compare behind a 3-cycle hazard
    run_xfer(OP_BLT,  32'h300, 32'h40, 32'hffffffff, 32'd1, 3, 0, 1'b1, 32'h340);
    run_xfer(OP_BLTU, 32'h300, 32'h40, 32'hffffffff, 32'd1, 3, 0, 1'b0, 32'h0);
    run_xfer(OP_BGEU, 32'h700, 32'hfffffff8, 32'hffffffff, 32'd1, 0, 0, 1'b1, 32'h6f8);
    run_xfer(OP_BGE,  32'h700, 32'h10, 32'hffffffff, 32'd1, 0, 0, 1'b0, 32'h0);
    // 4: JALR misaligned target, then JALR with bit 0 cleared
    run_xfer(OP_JALR, 32'h400, 32'h0, 32'h203, 32'h0, 0, 0, 1'b1, 32'h202);
    run_xfer(OP_JALR, 32'h404, 32'h0, 32'h201, 32'h0, 0, 0, 1'b1, 32'h200);
    // 5: JAL with a 4-cycle backpressured redirect
    run_xfer(OP_JAL, 32'h500, 32'h100, 32'h0, 32'h0, 0, 4, 1'b1, 32'h600);

    // 6a: flush while waiting on operands
    set_id(OP_BEQ, 32'h800, 32'h20, 32'd1, 32'd1, 1'b1);
    @(negedge clk);
    check("wait_stall", 32'(id_stall), 1);
    tick();
    check("wait_state", 32'(dbg_state), 32'(BRC_WAIT));
    ex_flush = 1'b1;
    id_opnd_hazard = 1'b0;
    @(negedge clk);
    check("flush_nostall", 32'(id_stall), 0);
    tick();
    ex_flush = 1'b0;
    clear_id();
    @(negedge clk);
    check("flush_wait_idle", 32'(dbg_state), 32'(BRC_IDLE));
    check("flush_wait_norv", 32'(redirect_valid), 0);
    check_counters();
    tick();

    // 6b: flush in the same cycle as a hazard-free request suppresses the resolve
    set_id(OP_JAL, 32'h900, 32'h40, 32'h0, 32'h0, 1'b0);
    ex_flush = 1'b1;
    tick();
    ex_flush = 1'b0;
    clear_id();
    @(negedge clk);
    check("flush_req_norv", 32'(redirect_valid), 0);
    check_counters();
    tick();

    // 6c: flush while a redirect is pending
    set_id(OP_JAL, 32'ha00, 32'h40, 32'h0, 32'h0, 1'b0);
    redirect_ready = 1'b0;
    tick();
    clear_id();
    exp_resolved++;
    exp_taken++;
    @(negedge clk);
    check("pend_rv", 32'(redirect_valid), 1);
    check("pend_pc", redirect_pc, 32'ha40);
    ex_flush = 1'b1;
    tick();
    ex_flush = 1'b0;
    @(negedge clk);
    check("flush_redir_rv", 32'(redirect_valid), 0);
    check("flush_redir_kill", 32'(id_kill), 0);
    check("flush_redir_state", 32'(dbg_state), 32'(BRC_IDLE));
    check_counters();
    tick();

    // 6d: async reset while a redirect is pending
    set_id(OP_JAL, 32'hb00, 32'h80, 32'h0, 32'h0, 1'b0);
    tick();
    clear_id();
    @(negedge clk);
    check("pre_rst_rv", 32'(redirect_valid), 1);
    rst_n = 1'b0;
    #1;
    exp_resolved = 0;
    exp_taken    = 0;
    check("async_rst_rv", 32'(redirect_valid), 0);
    check("async_rst_pc", redirect_pc, 0);
    check("async_rst_kill", 32'(id_kill), 0);
    check("async_rst_state", 32'(dbg_state), 32'(BRC_IDLE));
    check_counters();
    tick();
    rst_n = 1'b1;
    tick();
    tick();

    check("queue_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
